// File: rtl/posit_result_collector_if.sv
// Operand-side bus of the posit result collector: golden values in, pipeline results in.
interface posit_result_collector_if #(parameter int N = 32) ();
  logic         exp_valid;
  logic [N-1:0] exp_value;
  logic         done;
  logic [N-1:0] result;

  modport master (output exp_valid, exp_value, done, result);
  modport slave  (input  exp_valid, exp_value, done, result);
endinterface

// File: rtl/posit_result_collector.sv
// Collects golden posit values in a FIFO and scores pipeline results against them per run.
// Optional max-diff tracking is built only when POSIT_COLLECT_MAXDIFF_EN is defined.
module posit_result_collector #(
  parameter int N            = 32,
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  posit_result_collector_if.slave      bus,
  output logic                         mismatch,
  output logic [31:0]                  sample_count,
  output logic [31:0]                  error_count,
  output logic [N-1:0]                 max_diff,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         busy,
  output logic                         report_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
  state_t state, next;

  logic [DEPTH-1:0][N-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic [CW-1:0]           drain_cnt;

  logic         full, empty, active, run_entry;
  logic         pop, push_try, push;
  logic [N-1:0] head, diff;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign active    = (state == RUN) || (state == DRAIN);
  assign busy      = active;
  assign run_entry = (state == IDLE) && start;
  assign pop       = active && bus.done && !empty;
  assign push_try  = (state == RUN) && bus.exp_valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push      = push_try && (!full || pop);
  assign head      = mem[rd_ptr];
  assign diff      = (head >= bus.result) ? head - bus.result : bus.result - head;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = RUN;
      RUN:     if (!start) next = DRAIN;
      DRAIN:   if (start) next = RUN;
               else if (empty || drain_cnt == CW'(DRAIN_CYCLES - 1)) next = REPORT;
      REPORT:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drain_cnt    <= '0;
      mismatch     <= 1'b0;
      sample_count <= '0;
      error_count  <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      report_valid <= 1'b0;
    end else begin
      state        <= next;
      report_valid <= (state == DRAIN) && (next == REPORT);
      mismatch     <= pop && (diff != '0);
      drain_cnt    <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
      if (run_entry) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        sample_count <= '0;
        error_count  <= '0;
        overflow     <= 1'b0;
        underflow    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          if (sample_count != '1) sample_count <= sample_count + 32'd1;
          if (diff != '0 && error_count != '1) error_count <= error_count + 32'd1;
        end
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
        if (push_try && full && !pop) overflow <= 1'b1;
        if (active && bus.done && empty) underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.exp_value;
  end

`ifdef POSIT_COLLECT_MAXDIFF_EN
  always_ff @(posedge clk) begin
    if (reset || run_entry) max_diff <= '0;
    else if (pop && diff > max_diff) max_diff <= diff;
  end
`else
  assign max_diff = '0;
`endif
endmodule

// File: tb/tb_posit_result_collector.sv
// Directed bench: stimulus queues expected reports/snapshots, a monitor checks them.
module tb_posit_result_collector;
  localparam int N = 32;
`ifdef POSIT_COLLECT_MAXDIFF_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic         mismatch, overflow, underflow, busy, report_valid;
  logic [31:0]  sample_count, error_count;
  logic [N-1:0] max_diff;

  posit_result_collector_if #(.N(N)) bus ();

  posit_result_collector #(.N(N), .DEPTH(8), .DRAIN_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .mismatch(mismatch), .sample_count(sample_count), .error_count(error_count),
    .max_diff(max_diff), .overflow(overflow), .underflow(underflow),
    .busy(busy), .report_valid(report_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sc, ec; logic [N-1:0] md; logic ov, un; int cyc;
  } rep_t;
  typedef struct {
    string name; logic [31:0] sc, ec; logic [N-1:0] md; logic ov, un, bsy; int mis_cnt;
  } snap_t;

  rep_t  rep_q[$];
  snap_t snap_q[$];
  int    cyc = 0;
  int    vectors = 0, errors = 0, mis_seen = 0;
  bit    stim_done = 1'b0;
  logic [N-1:0] v3 [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] ov_val(input int i);
    return 32'h40000000 + 32'(i) * 32'h00100000 + 32'(i);
  endfunction

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    int rep_rd, snap_rd;
    rep_t r; snap_t s;
    rep_rd = 0; snap_rd = 0;
    forever begin
      @(negedge clk);
      if (mismatch === 1'b1) mis_seen++;
      if (report_valid === 1'b1) begin
        if (rep_rd >= rep_q.size()) chk("report_unexpected", {63'd0, report_valid}, 64'd0);
        else begin
          r = rep_q[rep_rd]; rep_rd++;
          chk("report.sample_count", sample_count, r.sc);
          chk("report.error_count", error_count, r.ec);
          chk("report.max_diff", max_diff, r.md);
          chk("report.overflow", overflow, r.ov);
          chk("report.underflow", underflow, r.un);
          chk("report.cycle", cyc, r.cyc);
        end
      end
      while (snap_rd < snap_q.size()) begin
        s = snap_q[snap_rd]; snap_rd++;
        chk({s.name, ".sample_count"}, sample_count, s.sc);
        chk({s.name, ".error_count"}, error_count, s.ec);
        chk({s.name, ".max_diff"}, max_diff, s.md);
        chk({s.name, ".overflow"}, overflow, s.ov);
        chk({s.name, ".underflow"}, underflow, s.un);
        chk({s.name, ".busy"}, busy, s.bsy);
        chk({s.name, ".mismatch"}, mismatch, 1'b0);
        chk({s.name, ".mismatch_pulses"}, mis_seen, s.mis_cnt);
        chk({s.name, ".report_valid"}, report_valid, 1'b0);
        mis_seen = 0;
      end
      if (stim_done) begin
        chk("reports_outstanding", rep_q.size() - rep_rd, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
      end
      if (cyc > 5000) begin
        vectors++; errors++;
        $display("FAIL watchdog: cycle %0d reached without completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_in();
    bus.exp_valid = 1'b0; bus.done = 1'b0;
  endtask

  task automatic snap(input string nm, input logic [31:0] sc, input logic [31:0] ec,
                      input logic [N-1:0] md, input logic ov, input logic un,
                      input logic bsy, input int mc);
    snap_t s;
    idle_in(); tick();
    s.name = nm; s.sc = sc; s.ec = ec; s.md = md; s.ov = ov; s.un = un; s.bsy = bsy; s.mis_cnt = mc;
    snap_q.push_back(s);
    @(negedge clk); #1;
  endtask

  task automatic expect_report(input logic [31:0] sc, input logic [31:0] ec,
                               input logic [N-1:0] md, input logic ov, input logic un,
                               input int dcyc);
    rep_t r;
    r.sc = sc; r.ec = ec; r.md = md; r.ov = ov; r.un = un; r.cyc = cyc + dcyc;
    rep_q.push_back(r);
  endtask

  initial begin : stim
    v3[0] = 32'h40000000; v3[1] = 32'h48000000; v3[2] = 32'h38000000;
    reset = 1'b1; start = 1'b0; idle_in();
    bus.exp_value = '0; bus.result = '0;
    wait_n(2);
    snap("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // three pushes, results returned 4 cycles later, all matching
    start = 1'b1; tick();
    for (int c = 0; c < 7; c++) begin
      bus.exp_valid = (c < 3);
      if (c < 3) bus.exp_value = v3[c];
      bus.done = (c >= 4);
      if (c >= 4) bus.result = v3[c-4];
      tick();
    end
    snap("aligned", 3, 0, 0, 0, 0, 1, 0);
    start = 1'b0; expect_report(3, 0, 0, 0, 0, 2);
    wait_n(4);

    // one error above the golden value, then one below it
    start = 1'b1; tick();
    bus.exp_valid = 1'b1; bus.exp_value = 32'h40000000; tick();
    bus.exp_valid = 1'b0; bus.done = 1'b1; bus.result = 32'h40000003; tick();
    snap("single_err", 1, 1, MD_EN ? 32'h3 : 32'h0, 0, 0, 1, 1);
    bus.exp_valid = 1'b1; bus.exp_value = 32'h48000000; tick();
    bus.exp_valid = 1'b0; bus.done = 1'b1; bus.result = 32'h47FFFFF0; tick();
    snap("below_err", 2, 2, MD_EN ? 32'h10 : 32'h0, 0, 0, 1, 1);
    start = 1'b0; expect_report(2, 2, MD_EN ? 32'h10 : 32'h0, 0, 0, 2);
    wait_n(4);

    // nine pushes into an 8-deep FIFO, then drain with the first eight plus one extra done
    start = 1'b1; tick();
    for (int i = 0; i < 9; i++) begin
      bus.exp_valid = 1'b1; bus.exp_value = ov_val(i); tick();
    end
    snap("overflow", 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      bus.done = 1'b1; bus.result = ov_val(i); tick();
    end
    snap("ovf_pops", 8, 0, 0, 1, 1, 1, 0);
    start = 1'b0; expect_report(8, 0, 0, 1, 1, 2);
    wait_n(4);

    // underflow, then drain with two pending results arriving 3 cycles after start falls
    start = 1'b1; tick();
    bus.done = 1'b1; bus.result = 32'h40000000; tick();
    snap("underflow", 0, 0, 0, 0, 1, 1, 0);
    bus.exp_valid = 1'b1; bus.exp_value = 32'h50000000; tick();
    bus.exp_value = 32'h30000000; tick();
    bus.exp_valid = 1'b0;
    start = 1'b0; expect_report(2, 0, 0, 0, 1, 6);
    wait_n(3);
    bus.done = 1'b1; bus.result = 32'h50000000; tick();
    bus.result = 32'h30000000; tick();
    bus.done = 1'b0;
    wait_n(3);
    bus.done = 1'b1; bus.exp_valid = 1'b1; bus.result = 32'h1; tick();
    snap("idle_hold", 2, 0, 0, 0, 1, 0, 0);

    // drain timeout: two entries pending, no results ever come
    start = 1'b1; tick();
    bus.exp_valid = 1'b1; bus.exp_value = 32'h40000000; tick();
    bus.exp_value = 32'h40000001; tick();
    bus.exp_valid = 1'b0;
    start = 1'b0; expect_report(0, 0, 0, 0, 0, 9);
    wait_n(12);

    // start re-asserted in DRAIN resumes the run without clearing
    start = 1'b1; tick();
    bus.exp_valid = 1'b1; bus.exp_value = 32'h44000000; tick();
    bus.exp_value = 32'h46000000; bus.done = 1'b1; bus.result = 32'h44000000; tick();
    idle_in(); start = 1'b0; tick();
    start = 1'b1; tick();
    bus.done = 1'b1; bus.result = 32'h46000000; tick();
    snap("redrain", 2, 0, 0, 0, 0, 1, 0);
    start = 1'b0; expect_report(2, 0, 0, 0, 0, 2);
    wait_n(4);

    // reset in the middle of a run with nonzero counters
    start = 1'b1; tick();
    bus.exp_valid = 1'b1; bus.exp_value = 32'h40000000; tick();
    bus.exp_valid = 1'b0; bus.done = 1'b1; bus.result = 32'h40000001; tick();
    snap("pre_reset", 1, 1, MD_EN ? 32'h1 : 32'h0, 0, 0, 1, 1);
    reset = 1'b1;
    snap("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b0; tick();
    reset = 1'b0;
    wait_n(12);
    snap("post_reset", 0, 0, 0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end
endmodule

// File: doc/posit_result_collector.md
POSIT_RESULT_COLLECTOR -- requirements
Module: posit_result_collector

Interface
REQ-001 Parameter N, default 32: posit word width.
REQ-002 Parameter DEPTH, default 8: expected-value FIFO depth, power of two, >= 2.
REQ-003 Parameter DRAIN_CYCLES, default 8: cycles waited after start falls before the block closes the run.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  run enable, same meaning as the multiplier start; high = run active.
REQ-007 exp_valid  input  1  exp_value is valid this cycle.
REQ-008 exp_value  input  N  golden posit for the next operand pair issued.
REQ-009 done  input  1  pipeline result valid (multiplier done).
REQ-010 result  input  N  normalized posit result from the pipeline.
REQ-011 mismatch  output  1  one-cycle pulse, registered: last compared result differed from the expected value.
REQ-012 sample_count  output  32  results compared in the current or last run.
REQ-013 error_count  output  32  mismatching results in the current or last run.
REQ-014 max_diff  output  N  largest absolute difference seen in the run.
REQ-015 overflow  output  1  sticky: a push was attempted while the FIFO was full.
REQ-016 underflow  output  1  sticky: done arrived while the FIFO was empty.
REQ-017 busy  output  1  state is RUN or DRAIN.
REQ-018 report_valid  output  1  one-cycle pulse: the run closed and the counters are final.

Function
REQ-019 States: IDLE, RUN, DRAIN, REPORT.
- IDLE->RUN when start is 1.
- RUN->DRAIN when start is 0.
- DRAIN->REPORT when the FIFO is empty or DRAIN_CYCLES have elapsed.
- REPORT->IDLE unconditionally after 1 cycle.
REQ-020 On entry to RUN, the block clears sample_count, error_count, max_diff, overflow, underflow and the FIFO in the same cycle.
REQ-021 Pushes are accepted only in RUN. A push is exp_valid=1 and not full. A push with exp_valid=1 while full sets overflow and the value is dropped.
REQ-022 Pops happen in RUN or DRAIN when done=1 and the FIFO is not empty. A pop compares result against the FIFO head.
REQ-023 Push and pop in the same cycle are both performed, including when the FIFO is full or empty. When the FIFO is empty, the pushed word is not the popped word; that case counts as underflow.
REQ-024 Comparison:
- diff = unsigned |head - result| at N bits.
- Mismatch when diff != 0.
- sample_count increments by 1.
- error_count increments on a mismatch.
- mismatch pulses 1 cycle after the pop.
REQ-025 done=1 while the FIFO is empty, in RUN or DRAIN: underflow is set and no counters change.
REQ-026 done, exp_valid and mismatch effects are ignored in IDLE and REPORT.
REQ-027 Counters saturate at 32'hFFFFFFFF; they do not wrap.
REQ-028 The DRAIN timeout counter starts at 0 on entry to DRAIN.
REQ-029 In DRAIN, report_valid is asserted on the cycle the state leaves DRAIN, registered, so it is high during REPORT only.
REQ-030 Outputs hold their values in IDLE until the next run starts.
REQ-031 start re-asserted during DRAIN returns the block to RUN without clearing counters.

Reset
REQ-032 reset=1 forces state to IDLE and the FIFO to empty.
REQ-033 reset=1 clears all outputs: mismatch, busy and report_valid to 0; counters, max_diff and flags to 0.
REQ-034 Reset mid-run discards the run; no report_valid is issued.
REQ-035 reset takes priority over all other inputs.

Configuration
REQ-036 Macro POSIT_COLLECT_MAXDIFF_EN.
- Defined: max_diff is updated on every pop where diff > max_diff.
- Undefined: the max_diff register is absent and the output is tied to 0.
- All other behaviour is identical in both cases.

Verification
REQ-037 Latency 4 alignment: set start=1. Push expected values 0x40000000, 0x48000000, 0x38000000. After 4 cycles, drive done with identical results. Required: sample_count=3, error_count=0, no mismatch pulse.
REQ-038 Single error: expected 0x40000000, result 0x40000003. Required: mismatch pulses once, error_count=1, max_diff=3; max_diff=0 when the macro is undefined.
REQ-039 Overflow: DEPTH=8. Push 9 values with no done. Required: overflow=1, FIFO holds the first 8, and the next 8 pops compare against those 8.
REQ-040 Underflow: done=1 with no push in RUN. Required: underflow=1, sample_count unchanged.
REQ-041 Drain and report: drop start with 2 entries pending, then deliver 2 done results 3 cycles later. Required: REPORT entered on the cycle after the FIFO empties, and report_valid is a single pulse. Repeat with no done: report_valid follows after DRAIN_CYCLES=8.
REQ-042 Reset mid-run: assert reset during RUN with counters nonzero. Required: next cycle state is IDLE, all outputs 0, and no report_valid.
